// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared fetch-stage types and default sizes for the PC/RAS unit
package pc_pkg;

    // Source selected for the next program counter value.
    typedef enum logic [2:0] {
        SEQ,
        HOLD,
        JUMP,
        CALL,
        RET,
        IRQ
    } pc_src_e;

    localparam int PC_WIDTH  = 16;
    localparam int RAS_DEPTH = 8;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - generic pointer-indexed LIFO used as the return-address stack
//   clock, reset (async, active-high)
//   push, pop, data_in : push/pop requests and push data
//   top                : entry at count-1 (undefined when empty)
//   count, full, empty : occupancy
// Push when full is dropped; pop when empty is ignored.
// Push and pop together on a non-empty stack replace the top entry.
module ras_lifo
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RAS_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             replace;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_idx  = count_q[AW-1:0];
    // When count == DEPTH the low bits wrap to 0, so top_idx lands on DEPTH-1.
    assign top_idx = count_q[AW-1:0] - AW'(1);
    assign replace = push && pop && !empty;
    assign top     = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (!replace) begin
            if (push && !full) begin
                count_d = count_q + CW'(1);
            end else if (pop && !empty) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset; entries above count are never read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (replace) begin
                mem_q[top_idx] <= data_in;
            end else if (push && !full) begin
                mem_q[wr_idx] <= data_in;
            end
        end
    end

endmodule

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware return-address stack
//   clock, reset (async, active-high)
//   stall, jump_en, call_en, return_en, jump_target, clear_flags : control inputs
//   current_pc  : registered fetch PC
//   next_pc     : combinational value current_pc takes at the next posedge
//   stack_count : valid RAS entries
//   overflow / underflow : sticky stack error flags
//   irq / in_irq : interrupt entry, present only with PC_INTERRUPT_EN defined
module pc_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter int               STACK_DEPTH  = RAS_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_INTERRUPT_EN
    ,
    parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'('h10)
`endif
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           jump_en,
    input  logic                           call_en,
    input  logic                           return_en,
    input  logic [WIDTH-1:0]               jump_target,
    input  logic                           clear_flags,
`ifdef PC_INTERRUPT_EN
    input  logic                           irq,
    output logic                           in_irq,
`endif
    output logic [WIDTH-1:0]               current_pc,
    output logic [WIDTH-1:0]               next_pc,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           overflow,
    output logic                           underflow
);

    pc_src_e          src;
    logic [WIDTH-1:0] current_pc_q;
    logic [WIDTH-1:0] pc_plus1;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             irq_take;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_data_in;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full;
    logic             ras_empty;

`ifdef PC_INTERRUPT_EN
    logic in_irq_q, in_irq_d;
    assign irq_take = irq && !in_irq_q && !stall;
    assign in_irq   = in_irq_q;
`else
    assign irq_take = 1'b0;
`endif

    assign pc_plus1 = current_pc_q + WIDTH'(1);

    always_comb begin
        src = SEQ;
        if (stall) begin
            src = HOLD;
        end else if (irq_take) begin
            src = IRQ;
        end else if (call_en && return_en) begin
            // Tail call: jump without touching the stack.
            src = JUMP;
        end else if (return_en) begin
            src = ras_empty ? SEQ : RET;
        end else if (call_en) begin
            src = CALL;
        end else if (jump_en) begin
            src = JUMP;
        end
    end

    always_comb begin
        case (src)
            HOLD:       next_pc = current_pc_q;
            JUMP, CALL: next_pc = jump_target;
            RET:        next_pc = ras_top;
`ifdef PC_INTERRUPT_EN
            IRQ:        next_pc = IRQ_VECTOR;
`endif
            default:    next_pc = pc_plus1;
        endcase
    end

    // An interrupt saves the instruction it pre-empted; a call saves the one after it.
    assign ras_push    = (src == CALL) || (src == IRQ);
    assign ras_pop     = (src == RET);
    assign ras_data_in = (src == IRQ) ? current_pc_q : pc_plus1;

    // A new error in the same cycle as clear_flags leaves the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!stall) begin
            overflow_d  = (overflow_q  && !clear_flags) || (ras_push && ras_full);
            underflow_d = (underflow_q && !clear_flags) || ((src == SEQ) && return_en);
        end
    end

`ifdef PC_INTERRUPT_EN
    always_comb begin
        in_irq_d = in_irq_q;
        if (irq_take) begin
            in_irq_d = 1'b1;
        end else if (return_en && !stall) begin
            in_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_irq_q <= 1'b0;
        end else begin
            in_irq_q <= in_irq_d;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            current_pc_q <= RESET_VECTOR;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            current_pc_q <= next_pc;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push    (ras_push),
        .pop     (ras_pop),
        .data_in (ras_data_in),
        .top     (ras_top),
        .count   (stack_count),
        .full    (ras_full),
        .empty   (ras_empty)
    );

    assign current_pc = current_pc_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed self-checking bench for pc_stack
module tb_pc_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_en;
    logic        call_en;
    logic        return_en;
    logic [15:0] jump_target;
    logic        clear_flags;
    logic [15:0] current_pc;
    logic [15:0] next_pc;
    logic [3:0]  stack_count;
    logic        overflow;
    logic        underflow;
`ifdef PC_INTERRUPT_EN
    logic        irq;
    logic        in_irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pc_stack #(
        .WIDTH       (16),
        .STACK_DEPTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .jump_en     (jump_en),
        .call_en     (call_en),
        .return_en   (return_en),
        .jump_target (jump_target),
        .clear_flags (clear_flags),
`ifdef PC_INTERRUPT_EN
        .irq         (irq),
        .in_irq      (in_irq),
`endif
        .current_pc  (current_pc),
        .next_pc     (next_pc),
        .stack_count (stack_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jump_en = 1'b0; call_en = 1'b0;
        return_en = 1'b0; jump_target = '0; clear_flags = 1'b0;
`ifdef PC_INTERRUPT_EN
        irq = 1'b0;
`endif
        // 1: reset without a clock edge, then idle counting
        #2;
        chk("rst_pc", current_pc, 0);
        chk("rst_cnt", stack_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        #1 reset = 1'b0;
        step(); chk("idle_pc1", current_pc, 1);
        step(); chk("idle_pc2", current_pc, 2);
        step(); chk("idle_pc3", current_pc, 3); chk("idle_cnt", stack_count, 0);
        step(); step(); chk("pc5", current_pc, 5);

        // 2: call at 0x0005, return at 0x0102
        call_en = 1'b1; jump_target = 16'h0100; #1;
        chk("call_next", next_pc, 16'h0100);
        step(); chk("call_pc", current_pc, 16'h0100); chk("call_cnt", stack_count, 1);
        call_en = 1'b0;
        step(); chk("body_pc1", current_pc, 16'h0101);
        step(); chk("body_pc2", current_pc, 16'h0102);
        return_en = 1'b1;
        step(); chk("ret_pc", current_pc, 16'h0006); chk("ret_cnt", stack_count, 0);
        return_en = 1'b0;

        // 3: nine nested calls (stack depth 8), then nine returns
        call_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            jump_target = 16'h1000 + 16'(i) * 16'h0100;
            step();
            chk("nest_pc", current_pc, 16'h1000 + 16'(i) * 16'h0100);
            chk("nest_cnt", stack_count, (i < 8) ? i + 1 : 8);
            chk("nest_ovf", overflow, (i == 8) ? 1 : 0);
        end
        call_en = 1'b0; return_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("unwind_pc", current_pc, (k < 7) ? 16'h1000 + 16'(6 - k) * 16'h0100 + 16'h1 : 16'h0007);
            chk("unwind_cnt", stack_count, 7 - k);
            chk("unwind_udf", underflow, 0);
        end
        step();
        chk("udf_pc", current_pc, 16'h0008);
        chk("udf_flag", underflow, 1);
        chk("udf_cnt", stack_count, 0);
        chk("ovf_sticky", overflow, 1);

        // clear_flags ignored under stall, loses to a new error, then clears
        return_en = 1'b0; stall = 1'b1; clear_flags = 1'b1;
        step(); chk("stclr_pc", current_pc, 16'h0008);
        chk("stclr_udf", underflow, 1); chk("stclr_ovf", overflow, 1);
        stall = 1'b0; return_en = 1'b1;
        step(); chk("errwin_pc", current_pc, 16'h0009);
        chk("errwin_udf", underflow, 1); chk("errwin_ovf", overflow, 0);
        return_en = 1'b0;
        step(); chk("clr_udf", underflow, 0); chk("clr_pc", current_pc, 16'h000A);
        clear_flags = 1'b0;

        // 4: call held under stall for 4 cycles
        stall = 1'b1; call_en = 1'b1; jump_target = 16'h0300; #1;
        chk("stall_next", next_pc, 16'h000A);
        for (int s = 0; s < 4; s++) begin
            step();
            chk("stall_pc", current_pc, 16'h000A);
            chk("stall_cnt", stack_count, 0);
        end
        stall = 1'b0;
        step(); chk("unstall_pc", current_pc, 16'h0300); chk("unstall_cnt", stack_count, 1);
        call_en = 1'b0; return_en = 1'b1;
        step(); chk("unstall_ret", current_pc, 16'h000B); chk("unstall_rcnt", stack_count, 0);
        return_en = 1'b0;

        // 5: wrap at all-ones, then tail call
        jump_en = 1'b1; jump_target = 16'hFFFF;
        step(); chk("jmp_ffff", current_pc, 16'hFFFF);
        jump_en = 1'b0; #1;
        chk("wrap_next", next_pc, 16'h0000);
        step(); chk("wrap_pc", current_pc, 16'h0000);
        chk("wrap_udf", underflow, 0); chk("wrap_ovf", overflow, 0);
        call_en = 1'b1; jump_target = 16'h0050;
        step(); chk("tc_pre_cnt", stack_count, 1);
        return_en = 1'b1; jump_target = 16'h0200;
        step(); chk("tail_pc", current_pc, 16'h0200); chk("tail_cnt", stack_count, 1);
        call_en = 1'b0;
        step(); chk("tail_ret_pc", current_pc, 16'h0001); chk("tail_ret_cnt", stack_count, 0);
        return_en = 1'b0;

        // reset mid-call aborts the push
        call_en = 1'b1; jump_target = 16'h0400;
        #2 reset = 1'b1;
        #1 chk("midrst_pc", current_pc, 0); chk("midrst_cnt", stack_count, 0);
        #1 reset = 1'b0; call_en = 1'b0;
        step(); chk("postrst_pc", current_pc, 1); chk("postrst_cnt", stack_count, 0);

`ifdef PC_INTERRUPT_EN
        // 6: interrupt entry, masked nesting, return
        jump_en = 1'b1; jump_target = 16'h0040;
        step(); jump_en = 1'b0;
        chk("irq_pre_pc", current_pc, 16'h0040);
        irq = 1'b1; call_en = 1'b1; jump_target = 16'h0999;
        step(); chk("irq_pc", current_pc, 16'h0010);
        chk("irq_in", in_irq, 1); chk("irq_cnt", stack_count, 1);
        call_en = 1'b0;
        step(); chk("irq_nest_pc", current_pc, 16'h0011); chk("irq_nest_cnt", stack_count, 1);
        irq = 1'b0; return_en = 1'b1;
        step(); chk("irq_ret_pc", current_pc, 16'h0040);
        chk("irq_ret_in", in_irq, 0); chk("irq_ret_cnt", stack_count, 0);
        return_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with a hardware return-address stack (RAS).
- Supports sequential increment, jump, call (push return address), return (pop), stall, and sticky stack error flags.
- Sits in the fetch stage: current_pc drives instruction memory; control decode drives jump/call/return.
- Replaces the fixed 16-bit negedge/posedge PC with a single-edge, width-generic unit.

Parameters:
- WIDTH, 16: PC and target width in bits.
- STACK_DEPTH, 8: RAS entries; power of two, at least 2.
- RESET_VECTOR, 0: current_pc value after reset.
- IRQ_VECTOR, 16'h0010: interrupt entry address. Used only with PC_INTERRUPT_EN.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- stall  input  1  hold all state this cycle.
- jump_en  input  1  load jump_target.
- call_en  input  1  push current_pc+1, then load jump_target.
- return_en  input  1  load popped top of stack.
- jump_target  input  WIDTH  destination for jump/call.
- clear_flags  input  1  clear sticky error flags.
- current_pc  output  WIDTH  registered PC of the instruction being fetched.
- next_pc  output  WIDTH  combinational value current_pc takes at the next posedge.
- stack_count  output  $clog2(STACK_DEPTH)+1  valid RAS entries.
- overflow  output  1  sticky: a call was made with the stack full.
- underflow  output  1  sticky: a return was made with the stack empty.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately regardless of clock.
  - current_pc = RESET_VECTOR, stack_count = 0, overflow = 0, underflow = 0.
  - RAS contents are don't-care.
  - Reset asserted mid-call or mid-return aborts the operation; no partial push or pop is retained.
- next_pc is a combinational mux evaluated in priority order:
  - stall: current_pc.
  - call_en and return_en together: jump_target. Stack unchanged (tail call).
  - return_en with stack_count > 0: top of stack.
  - return_en with stack empty: current_pc+1.
  - call_en or jump_en: jump_target.
  - otherwise: current_pc+1.
- On posedge:
  - current_pc <= next_pc.
  - The stack is updated only when stall = 0.
- Increment wraps modulo 2^WIDTH; current_pc = all-ones goes to 0. No flag is raised.
- Call, not full: write current_pc+1 (wrapped) at index stack_count; stack_count+1.
- Call, full: the push is dropped, stack_count stays at STACK_DEPTH, overflow <= 1. The jump still occurs.
- Return, not empty: stack_count-1; the popped value is the entry at stack_count-1.
- Return, empty: stack_count stays 0, underflow <= 1. PC increments.
- A call with jump_en also asserted behaves as a call alone.
- Latency: a call, return or jump asserted in cycle N is visible on current_pc in cycle N+1. There is no extra bubble.
- Error flags:
  - clear_flags zeroes both flags on the next posedge.
  - If a new error occurs in the same cycle as clear_flags, the error wins and the flag ends at 1.
  - clear_flags is ignored while stall = 1.
- The stack is pointer-indexed storage, not a shift register.

Optional Feature:
- Macro: PC_INTERRUPT_EN.
- When defined, adds ports irq (input, 1) and in_irq (output, 1, reset 0).
- Interrupt entry:
  - Condition: irq = 1, in_irq = 0, stall = 0.
  - Action: push current_pc (the not-yet-executed instruction) and set next_pc = IRQ_VECTOR.
  - Priority: above call/return/jump; those inputs are ignored that cycle.
  - in_irq <= 1.
  - Full stack on entry: overflow <= 1, entry still taken.
- A return while in_irq = 1 clears in_irq. Nested interrupts are masked.
- When not defined: no irq/in_irq ports, no interrupt logic; behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC source enum {SEQ, HOLD, JUMP, CALL, RET, IRQ};
  - default WIDTH and STACK_DEPTH constants, reused by the fetch and decode stages.
- One natural sub-module: ras_lifo, a generic LIFO.
  - Parameters WIDTH and DEPTH.
  - Signals: push, pop, data_in, top, count, full, empty.
  - Keeps the RAS reusable by a future data-stack unit.

Test Plan:
1. Reset pulse with no clock edge, then 3 clocks idle: current_pc reads 0 immediately after reset asserts, then 1, 2, 3; stack_count = 0.
2. At pc = 0x0005, call_en with target 0x0100, then return_en at 0x0102: pc sequence 0x0100, 0x0101, 0x0102, 0x0006; stack_count goes 1 then 0.
3. 9 nested calls with STACK_DEPTH = 8: overflow = 1 after the 9th call, stack_count = 8; 8 returns unwind correctly; a 9th return sets underflow = 1 and the pc increments.
4. stall held for 4 cycles during call_en: current_pc and stack_count are frozen; the call executes on the first unstalled cycle.
5. current_pc = 0xFFFF with no controls: next_pc = 0x0000. Simultaneous call_en and return_en with target 0x0200: pc = 0x0200, stack unchanged.
6. With PC_INTERRUPT_EN, irq at pc = 0x0040: pc = 0x0010, in_irq = 1. A second irq is ignored. Return gives pc = 0x0040 and in_irq = 0.
